// File: rtl/fp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_pkg : shared floating-point format helpers, constants and types
// Rev 1.0
// ------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EW    = 4;
  localparam int FP_MW    = 7;
  localparam int EXP_ZERO = 0;
  localparam int EXP_INF  = (1 << FP_EW) - 1;

  function automatic int fp_word_width(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_exp_inf(input int ew);
    return (1 << ew) - 1;
  endfunction

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;

  typedef struct packed {
    logic             sign;
    logic [FP_EW-1:0] exp;
    logic [FP_MW:0]   mant;
  } fp_unpacked_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_lzc : combinational leading-zero counter (all-zero input -> WIDTH)
// Rev 1.0
// ------------------------------------------------------------------
module fp_lzc #(
  parameter  int WIDTH = 12,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  logic w_found;

  always_comb begin
    o_count = '0;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (i_data[i]) w_found = 1'b1;
        else           o_count = o_count + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_addsub_pipe : 3-stage round-to-nearest-even FP adder/subtractor
// Rev 1.0
// ------------------------------------------------------------------
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EW = 4,
  parameter  int MW = 7,
  localparam int W  = fp_word_width(EW, MW)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf,
  output logic         inx
);

  // Aligned mantissa layout: {hidden, mant[MW-1:0], G, R, sticky}
  localparam int AW  = MW + 4;
  localparam int SW  = MW + 5;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EW + LZW + 1;

  localparam logic [EW-1:0]        c_EXP_INF  = EW'(fp_exp_inf(EW));
  localparam logic [EW-1:0]        c_EXP_ZERO = EW'(EXP_ZERO);
  localparam logic signed [XW-1:0] c_X_ZERO   = '0;
  localparam logic signed [XW-1:0] c_X_ONE    = XW'(1);
  localparam logic signed [XW-1:0] c_X_INF    = XW'(fp_exp_inf(EW));

  logic w_en;
  logic r_out_valid;
  logic [W-1:0] r_result;
  fp_flags_t r_flags;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_flags.ovf;
  assign unf       = r_flags.unf;
  assign inx       = r_flags.inx;

  // ---------------- S1: unpack / swap / align ----------------
  logic          w_sa, w_sb;
  logic [EW-1:0] w_ea, w_eb;
  logic [MW-1:0] w_ma, w_mb;
  logic          w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_ge_b;
  logic          w_sl;
  logic [EW-1:0] w_el, w_es, w_d;
  logic [MW-1:0] w_ml, w_ms;
  logic [AW-1:0] w_ms_full, w_ms_al;
  logic [2*AW-1:0] w_wide;
  logic          w_spec;
  logic [W-1:0]  w_spec_res;
  fp_flags_t     w_spec_flg;

  assign w_sa = a[W-1];
  assign w_ea = a[W-2:MW];
  assign w_ma = a[MW-1:0];
  assign w_sb = b[W-1] ^ op;
  assign w_eb = b[W-2:MW];
  assign w_mb = b[MW-1:0];

  assign w_a_zero = (w_ea == c_EXP_ZERO);
  assign w_b_zero = (w_eb == c_EXP_ZERO);
  assign w_a_inf  = (w_ea == c_EXP_INF);
  assign w_b_inf  = (w_eb == c_EXP_INF);
  assign w_a_ge_b = ({w_ea, w_ma} >= {w_eb, w_mb});

  assign w_sl = w_a_ge_b ? w_sa : w_sb;
  assign w_el = w_a_ge_b ? w_ea : w_eb;
  assign w_es = w_a_ge_b ? w_eb : w_ea;
  assign w_ml = w_a_ge_b ? w_ma : w_mb;
  assign w_ms = w_a_ge_b ? w_mb : w_ma;
  assign w_d  = w_el - w_es;

  assign w_ms_full = {1'b1, w_ms, 3'b000};
  assign w_wide    = {w_ms_full, {AW{1'b0}}} >> w_d;

  always_comb begin
    if (int'(w_d) >= MW + 3) w_ms_al = {{(AW-1){1'b0}}, 1'b1};
    else w_ms_al = {w_wide[2*AW-1:AW+1], w_wide[AW] | (|w_wide[AW-1:0])};
  end

  // Infinity and zero operands bypass the arithmetic path entirely
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_a_inf && w_b_inf) begin
      if (w_sa != w_sb) begin
        w_spec_res     = {1'b0, c_EXP_INF, {MW{1'b0}}};
        w_spec_flg.ovf = 1'b1;
      end else begin
        w_spec_res = {w_sa, c_EXP_INF, {MW{1'b0}}};
      end
    end else if (w_a_inf) begin
      w_spec_res = {w_sa, c_EXP_INF, {MW{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_sb, c_EXP_INF, {MW{1'b0}}};
    end else if (w_a_zero) begin
      w_spec_res = {w_sb, w_eb, w_b_zero ? {MW{1'b0}} : w_mb};
    end else if (w_b_zero) begin
      w_spec_res = {w_sa, w_ea, w_ma};
    end else begin
      w_spec = 1'b0;
    end
  end

  logic          r1_valid, r1_spec, r1_sign, r1_sub;
  logic [W-1:0]  r1_spec_res;
  fp_flags_t     r1_spec_flg;
  logic [EW-1:0] r1_exp;
  logic [AW-1:0] r1_ml, r1_ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r1_spec     <= 1'b0;
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_spec_res <= '0;
      r1_spec_flg <= '0;
      r1_exp      <= '0;
      r1_ml       <= '0;
      r1_ms       <= '0;
    end else if (w_en) begin
      r1_valid    <= in_valid;
      r1_spec     <= w_spec;
      r1_sign     <= w_sl;
      r1_sub      <= w_sa ^ w_sb;
      r1_spec_res <= w_spec_res;
      r1_spec_flg <= w_spec_flg;
      r1_exp      <= w_el;
      r1_ml       <= {1'b1, w_ml, 3'b000};
      r1_ms       <= w_ms_al;
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic [SW-1:0] w_sum;
  assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                        : ({1'b0, r1_ml} + {1'b0, r1_ms});

  logic          r2_valid, r2_spec, r2_sign;
  logic [W-1:0]  r2_spec_res;
  fp_flags_t     r2_spec_flg;
  logic [EW-1:0] r2_exp;
  logic [SW-1:0] r2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid    <= 1'b0;
      r2_spec     <= 1'b0;
      r2_sign     <= 1'b0;
      r2_spec_res <= '0;
      r2_spec_flg <= '0;
      r2_exp      <= '0;
      r2_sum      <= '0;
    end else if (w_en) begin
      r2_valid    <= r1_valid;
      r2_spec     <= r1_spec;
      r2_sign     <= r1_sign;
      r2_spec_res <= r1_spec_res;
      r2_spec_flg <= r1_spec_flg;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [LZW-1:0] w_lz;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .i_data  (r2_sum),
    .o_count (w_lz)
  );

  logic [AW-1:0]        w_norm;
  logic signed [XW-1:0] w_exp_l_x, w_lz_x, w_exp_n, w_exp_r;
  logic                 w_g, w_r, w_st, w_up;
  logic [MW+1:0]        w_mr;
  logic [MW-1:0]        w_mant;
  logic [W-1:0]         w_res;
  fp_flags_t            w_flg;

  assign w_exp_l_x = {{(XW-EW){1'b0}}, r2_exp};
  assign w_lz_x    = {{(XW-LZW){1'b0}}, w_lz};

  // Sum bit SW-2 is the hidden position, so the shift is one less than the count
  always_comb begin
    if (r2_sum[SW-1]) begin
      w_norm  = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = w_exp_l_x + c_X_ONE;
    end else begin
      w_norm  = r2_sum[AW-1:0] << (w_lz - LZW'(1));
      w_exp_n = w_exp_l_x + c_X_ONE - w_lz_x;
    end
  end

  assign w_g     = w_norm[2];
  assign w_r     = w_norm[1];
  assign w_st    = w_norm[0];
  assign w_up    = w_g & (w_r | w_st | w_norm[3]);
  assign w_mr    = {1'b0, w_norm[AW-1:3]} + (MW+2)'(w_up);
  assign w_exp_r = w_exp_n + (w_mr[MW+1] ? c_X_ONE : c_X_ZERO);
  assign w_mant  = w_mr[MW+1] ? w_mr[MW:1] : w_mr[MW-1:0];

  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_flg = r2_spec_flg;
    end else if (r2_sum == '0) begin
      w_res = '0;
    end else if (w_exp_n <= c_X_ZERO) begin
      w_res     = {r2_sign, {(W-1){1'b0}}};
      w_flg.unf = 1'b1;
      w_flg.inx = 1'b1;
    end else if (w_exp_r >= c_X_INF) begin
      w_res     = {r2_sign, c_EXP_INF, {MW{1'b0}}};
      w_flg.ovf = 1'b1;
      w_flg.inx = 1'b1;
    end else begin
      w_res     = {r2_sign, w_exp_r[EW-1:0], w_mant};
      w_flg.inx = w_g | w_r | w_st;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      r_result    <= w_res;
      r_flags     <= w_flg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fp_addsub_pipe : directed self-checking bench for fp_addsub_pipe
// Rev 1.0
// ------------------------------------------------------------------
module tb_fp_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic        ovf;
  logic        unf;
  logic        inx;

  int n_asserts;
  int n_fail;

  fp_addsub_pipe #(.EW(4), .MW(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .inx       (inx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation; checks latency, result and the flags selected by fmask
  task automatic single_op(input string tag, input logic [11:0] ia, input logic [11:0] ib,
                           input logic iop, input logic [11:0] eres,
                           input logic [2:0] eflg, input logic [2:0] fmask);
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 12'(out_valid), 12'd0);
    @(negedge clk);
    check({tag, "_valid"}, 12'(out_valid), 12'd1);
    check({tag, "_result"}, result, eres);
    check({tag, "_flags"}, 12'({ovf, unf, inx} & fmask), 12'(eflg & fmask));
  endtask

  logic [11:0] s_a [5];
  logic [11:0] s_exp [5];
  logic [11:0] held;
  int sent, got, stall;

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_out_valid", 12'(out_valid), 12'd0);
    check("reset_result", result, 12'h000);
    check("reset_flags", 12'({ovf, unf, inx}), 12'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 12'(in_ready), 12'd1);

    // flags are {ovf, unf, inx}
    single_op("add_1p1",   12'h380, 12'h380, 1'b0, 12'h400, 3'b000, 3'b111);
    single_op("sub_cancel",12'h380, 12'h380, 1'b1, 12'h000, 3'b000, 3'b111);
    single_op("add_mixed", 12'h3C0, 12'hB80, 1'b0, 12'h300, 3'b000, 3'b111);
    single_op("sub_align", 12'h400, 12'h380, 1'b1, 12'h380, 3'b000, 3'b111);
    single_op("rne_tie",   12'h480, 12'h080, 1'b0, 12'h480, 3'b001, 3'b111);
    single_op("rne_up",    12'h480, 12'h081, 1'b0, 12'h481, 3'b001, 3'b111);
    single_op("overflow",  12'h77F, 12'h77F, 1'b0, 12'h780, 3'b101, 3'b111);
    single_op("inf_minf",  12'h780, 12'hF80, 1'b0, 12'h780, 3'b100, 3'b100);
    single_op("underflow", 12'h0C0, 12'h080, 1'b1, 12'h000, 3'b011, 3'b111);
    single_op("zero_a_sub",12'h000, 12'h3C0, 1'b1, 12'hBC0, 3'b000, 3'b111);
    single_op("zero_b",    12'h3C0, 12'h000, 1'b0, 12'h3C0, 3'b000, 3'b111);
    single_op("inf_plus",  12'h780, 12'h3C0, 1'b0, 12'h780, 3'b000, 3'b000);

    // Backpressure: x + x for exponents 7..11 doubles to exponents 8..12
    for (int i = 0; i < 5; i++) begin
      s_a[i]   = 12'((7 + i) << 7);
      s_exp[i] = 12'((8 + i) << 7);
    end
    sent = 0; got = 0; stall = 0; held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(got >= 1 && stall < 4);
      if (sent < 5) begin
        a = s_a[sent]; b = s_a[sent]; op = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        if (stall == 0) begin
          held = result;
          check("bp_in_ready_drop", 12'(in_ready), 12'd0);
        end else begin
          check("bp_hold", result, held);
        end
        stall++;
      end
      if (out_valid && out_ready) begin
        if (got < 5) check("bp_order", result, s_exp[got]);
        else check("bp_duplicate", 12'(out_valid), 12'd0);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", 12'(got), 12'd5);
    check("bp_stalled", 12'(stall >= 4), 12'd1);

    // Asynchronous reset while results are in flight
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = s_a[i]; b = s_a[i]; op = 1'b0; in_valid = 1'b1;
    end
    #2;
    check("rst_pre_valid", 12'(out_valid), 12'd1);
    rst = 1'b1;
    #1;
    check("rst_out_valid", 12'(out_valid), 12'd0);
    check("rst_result", result, 12'h000);
    check("rst_flags", 12'({ovf, unf, inx}), 12'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 12'(in_ready), 12'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_discard", 12'(out_valid), 12'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
